// File: rtl/ntt_load_if.sv
// ntt_load_if: groups the coefficient-load stream, RAM write port and status
// signals of ntt_load.
//   master : front end / bench side (drives enable, s_data, s_valid)
//   slave  : ntt_load side (drives s_ready, Coef_*, busy, done, chksum)
interface ntt_load_if;
  localparam int unsigned BEAT_W = 32;
  localparam int unsigned WORD_W = 3072;
  localparam int unsigned AD_W   = 8;

  logic              enable;
  logic [BEAT_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [AD_W-1:0]   Coef_WAd;
  logic [WORD_W-1:0] Coef_WData;
  logic              Coef_WEn;
  logic              busy;
  logic              done;
  logic [BEAT_W-1:0] chksum;

  modport master (
    output enable, s_data, s_valid,
    input  s_ready, Coef_WAd, Coef_WData, Coef_WEn, busy, done, chksum
  );

  modport slave (
    input  enable, s_data, s_valid,
    output s_ready, Coef_WAd, Coef_WData, Coef_WEn, busy, done, chksum
  );
endinterface

// File: rtl/ntt_load.sv
// ntt_load: assembles 96 x 32-bit stream beats into 3072-bit coefficient RAM
// words and issues one write strobe per word, NUM_WORDS words per load starting
// at BASE_AD (address wraps at 255).
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : ntt_load_if.slave
//            in : enable (start, sampled in IDLE/DONE), s_data, s_valid
//            out: s_ready, Coef_WAd, Coef_WData, Coef_WEn, busy, done, chksum
// Optional feature: define NTT_LOAD_CHKSUM_EN to build the XOR checksum of
// accepted beats; otherwise chksum is tied to zero.
module ntt_load #(
  parameter int unsigned NUM_WORDS = 2,
  parameter int unsigned BASE_AD   = 0
) (
  input  logic       clk,
  input  logic       reset,
  ntt_load_if.slave  bus
);
  localparam int unsigned BEAT_W = 32;
  localparam int unsigned BEATS  = 96;
  localparam int unsigned WORD_W = BEAT_W * BEATS;
  localparam int unsigned BCNT_W = 7;
  localparam int unsigned AD_W   = 8;
  localparam int unsigned SEL_W  = 12;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);
  localparam logic [AD_W-1:0]   LAST_WORD = AD_W'(NUM_WORDS - 1);
  localparam logic [AD_W-1:0]   BASE      = AD_W'(BASE_AD);

  logic [1:0]        state_q,    state_d;
  logic [BCNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [AD_W-1:0]   word_cnt_q, word_cnt_d;
  logic [AD_W-1:0]   wad_q,      wad_d;
  logic [WORD_W-1:0] wdata_q,    wdata_d;
  logic              wen_q,      wen_d;
  logic              ready_q,    ready_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
  logic              start_c;
  logic              accept_c;
  logic [SEL_W-1:0]  slot_lsb_c;

  // Beat n lands at bit 32n: index is beat_cnt with five zero LSBs.
  assign slot_lsb_c = {SEL_W'(beat_cnt_q)} << 5;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      beat_cnt_q <= '0;
      word_cnt_q <= '0;
      wad_q      <= '0;
      wdata_q    <= '0;
      wen_q      <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      word_cnt_q <= word_cnt_d;
      wad_q      <= wad_d;
      wdata_q    <= wdata_d;
      wen_q      <= wen_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next state and registered-output decode
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    word_cnt_d = word_cnt_q;
    wad_d      = wad_q;
    wdata_d    = wdata_q;
    done_d     = done_q;
    start_c    = 1'b0;
    accept_c   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.enable) begin
          start_c    = 1'b1;
          state_d    = S_FILL;
          beat_cnt_d = '0;
          word_cnt_d = '0;
          wad_d      = BASE;
          done_d     = 1'b0;
        end
      end
      S_FILL: begin
        accept_c = bus.s_valid && ready_q;
        if (accept_c) begin
          wdata_d[slot_lsb_c +: BEAT_W] = bus.s_data;
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            state_d    = S_WRITE;
          end else begin
            beat_cnt_d = beat_cnt_q + BCNT_W'(1);
          end
        end
      end
      S_WRITE: begin
        if (word_cnt_q == LAST_WORD) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d    = S_FILL;
          word_cnt_d = word_cnt_q + AD_W'(1);
          wad_d      = wad_q + AD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs follow the state being entered so they line up with it.
    ready_d = (state_d == S_FILL);
    wen_d   = (state_d == S_WRITE);
    busy_d  = (state_d == S_FILL) || (state_d == S_WRITE);
  end

  assign bus.s_ready    = ready_q;
  assign bus.Coef_WAd   = wad_q;
  assign bus.Coef_WData = wdata_q;
  assign bus.Coef_WEn   = wen_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

`ifdef NTT_LOAD_CHKSUM_EN
  logic [BEAT_W-1:0] chk_q, chk_d;

  // XOR accumulator over accepted beats, cleared on start
  always_comb begin
    chk_d = chk_q;
    if (start_c) begin
      chk_d = '0;
    end else if (accept_c) begin
      chk_d = chk_q ^ bus.s_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_q <= '0;
    end else begin
      chk_q <= chk_d;
    end
  end

  assign bus.chksum = chk_q;
`else
  assign bus.chksum = '0;
`endif

endmodule

// File: tb/tb_ntt_load.sv
// tb_ntt_load: directed bench for ntt_load. Two instances share stimulus:
// u_dut0 (BASE_AD=0) and u_dut1 (BASE_AD=255), both NUM_WORDS=2.
module tb_ntt_load;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ntt_load_if if0 ();
  ntt_load_if if1 ();

  ntt_load #(.NUM_WORDS(2), .BASE_AD(0)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0.slave)
  );

  ntt_load #(.NUM_WORDS(2), .BASE_AD(255)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int e_cyc = 0;
  int lat;

  int             wr_cnt0, wr_cnt1, viol;
  logic [7:0]     wr_ad0 [4];
  logic [7:0]     wr_ad1 [4];
  logic [3071:0]  wr_dat0 [4];
  logic [3071:0]  wr_dat1 [4];
  logic [31:0]    exp_chk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write-port monitor
  always @(negedge clk) begin
    if (if0.Coef_WEn) begin
      if (wr_cnt0 < 4) begin
        wr_ad0[wr_cnt0]  = if0.Coef_WAd;
        wr_dat0[wr_cnt0] = if0.Coef_WData;
      end
      wr_cnt0++;
    end
    if (if1.Coef_WEn) begin
      if (wr_cnt1 < 4) begin
        wr_ad1[wr_cnt1]  = if1.Coef_WAd;
        wr_dat1[wr_cnt1] = if1.Coef_WData;
      end
      wr_cnt1++;
    end
    if ((if0.Coef_WEn && if0.s_ready) || (if1.Coef_WEn && if1.s_ready)) viol++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] beat_val(input int mode, input int n);
    if (mode == 0) return 32'(n);
    return (n < 96) ? 32'hA5A5A5A5 : 32'h0000FFFF;
  endfunction

  task automatic drive(input logic en, input logic v, input logic [31:0] d);
    if0.enable = en;  if1.enable = en;
    if0.s_valid = v;  if1.s_valid = v;
    if0.s_data = d;   if1.s_data = d;
  endtask

  task automatic clr_log();
    wr_cnt0 = 0;
    wr_cnt1 = 0;
    viol    = 0;
  endtask

  // Pulse enable for one cycle; returns at the negedge after the sampling edge.
  task automatic start();
    @(negedge clk);
    drive(1'b1, 1'b0, $urandom);
    @(negedge clk);
    drive(1'b0, 1'b0, $urandom);
    e_cyc = cyc;
  endtask

  // Push beats until stop_at are accepted; gap is the % chance of an idle cycle.
  task automatic feed(input int mode, input int gap, input int stop_at, input bit poke_en);
    int n = 0;
    int budget = 0;
    logic v;
    logic [31:0] d;
    exp_chk = '0;
    while (n < stop_at && budget < 4000) begin
      v = ($urandom_range(99) >= gap);
      d = v ? beat_val(mode, n) : $urandom;
      drive(poke_en && ((n == 40) || if0.Coef_WEn), v, d);
      if (v && if0.s_ready) begin
        exp_chk = exp_chk ^ d;
        n++;
      end
      @(negedge clk);
      budget++;
    end
    drive(1'b0, 1'b0, $urandom);
    chk("feed_beats", 32'(n), 32'(stop_at));
  endtask

  task automatic wait_done();
    int b = 0;
    while (!if0.done && b < 3000) begin
      @(negedge clk);
      b++;
    end
    lat = cyc - e_cyc;
    chk("done_seen", 32'(if0.done), 32'd1);
    @(negedge clk);
  endtask

  task automatic chk_word(input string tag, input logic [3071:0] w, input int mode, input int word);
    int s = 95;
    for (int i = 95; i >= 0; i--) begin
      if (w[i*32 +: 32] !== beat_val(mode, 96*word + i)) s = i;
    end
    chk(tag, w[s*32 +: 32], beat_val(mode, 96*word + s));
  endtask

  task automatic chk_load(input string tag, input int mode);
    #1;
    chk({tag, "_nwr0"}, 32'(wr_cnt0), 32'd2);
    chk({tag, "_nwr1"}, 32'(wr_cnt1), 32'd2);
    chk({tag, "_ad0_0"}, 32'(wr_ad0[0]), 32'd0);
    chk({tag, "_ad0_1"}, 32'(wr_ad0[1]), 32'd1);
    chk({tag, "_ad1_0"}, 32'(wr_ad1[0]), 32'd255);
    chk({tag, "_ad1_1"}, 32'(wr_ad1[1]), 32'd0);
    chk_word({tag, "_w0_d0"}, wr_dat0[0], mode, 0);
    chk_word({tag, "_w1_d0"}, wr_dat0[1], mode, 1);
    chk_word({tag, "_w0_d1"}, wr_dat1[0], mode, 0);
    chk_word({tag, "_w1_d1"}, wr_dat1[1], mode, 1);
    chk({tag, "_done"}, 32'(if0.done), 32'd1);
    chk({tag, "_busy"}, 32'(if0.busy), 32'd0);
    chk({tag, "_ready"}, 32'(if0.s_ready), 32'd0);
    chk({tag, "_rdy_in_wr"}, 32'(viol), 32'd0);
`ifdef NTT_LOAD_CHKSUM_EN
    chk({tag, "_chksum"}, if0.chksum, exp_chk);
`else
    chk({tag, "_chksum"}, if0.chksum, 32'h0);
`endif
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(if0.s_ready | if1.s_ready), 32'd0);
    chk({tag, "_wad0"}, 32'(if0.Coef_WAd), 32'd0);
    chk({tag, "_wad1"}, 32'(if1.Coef_WAd), 32'd0);
    chk({tag, "_wdata"}, 32'(|if0.Coef_WData | |if1.Coef_WData), 32'd0);
    chk({tag, "_wen"}, 32'(if0.Coef_WEn | if1.Coef_WEn), 32'd0);
    chk({tag, "_busy"}, 32'(if0.busy | if1.busy), 32'd0);
    chk({tag, "_done"}, 32'(if0.done | if1.done), 32'd0);
    chk({tag, "_chksum"}, if0.chksum | if1.chksum, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    clr_log();
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    reset = 1'b0;

    // Continuous stream, index data, latency check
    start();
    chk("c_ready_after_en", 32'(if0.s_ready), 32'd1);
    chk("c_busy_after_en", 32'(if0.busy), 32'd1);
    chk("c_wad_after_en", 32'(if1.Coef_WAd), 32'd255);
    feed(0, 0, 192, 1'b0);
    wait_done();
    chk("c_latency", 32'(lat), 32'd194);
    chk_load("cont", 0);

    // 50% gaps, same data; restart from DONE clears done next cycle
    clr_log();
    start();
    chk("g_done_cleared", 32'(if0.done), 32'd0);
    feed(0, 50, 192, 1'b0);
    wait_done();
    chk_load("gap", 0);

    // enable pulsed during FILL and WRITE is ignored
    clr_log();
    start();
    feed(0, 20, 192, 1'b1);
    wait_done();
    chk_load("poke", 0);

    // Checksum pattern
    clr_log();
    start();
    feed(1, 30, 192, 1'b0);
    wait_done();
    chk_load("pat", 1);
    chk("pat_chksum_zero", if0.chksum, 32'h0);

    // Reset at beat 50 of word 1
    clr_log();
    start();
    feed(0, 0, 146, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk_reset_vals("mid");
    chk("mid_nwr", 32'(wr_cnt0), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("mid_no_wen", 32'(wr_cnt0), 32'd1);
    clr_log();
    start();
    feed(0, 0, 192, 1'b0);
    wait_done();
    chk_load("after_rst", 0);

    // Reset during a write drops the strobe at once
    clr_log();
    start();
    feed(0, 0, 96, 1'b0);
    chk("wr_wen_before", 32'(if0.Coef_WEn), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("wr_wen_async", 32'(if0.Coef_WEn | if1.Coef_WEn), 32'd0);
    chk("wr_wad_async", 32'(if1.Coef_WAd), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
